// File: rtl/button_ctrl.sv
// button_ctrl: debounced 5-button peripheral with press/release pending flags, mask and irq
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  button,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [12:0] EV = 13'h1f1f;
  logic [4:0] s1, sync, stable, stable_nxt;
  logic [CW-1:0] cnt [5];
  logic [CW-1:0] cnt_nxt [5];
  logic [12:0] pend, pend_nxt, mask, mask_nxt, ev_set, clr;
  logic unused_bits;
  assign unused_bits = ^wdata[31:13];
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < 5; i++) begin
      cnt_nxt[i] = (sync[i] == stable[i] || cnt[i] == CMAX) ? '0 : cnt[i] + 1'b1;
      stable_nxt[i] = (sync[i] != stable[i] && cnt[i] == CMAX) ? sync[i] : stable[i];
    end
  end
  always_comb begin
    ev_set = {3'b0, stable & ~stable_nxt, 3'b0, stable_nxt & ~stable};
    clr = (we && addr == 2'd1) ? wdata[12:0] & EV : 13'h0;
    pend_nxt = (pend & ~clr) | ev_set;
    mask_nxt = (we && addr == 2'd2) ? wdata[12:0] & EV : mask;
    rdata = addr == 2'd0 ? {27'b0, stable} :
            addr == 2'd1 ? {19'b0, pend} :
            addr == 2'd2 ? {19'b0, mask} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      sync <= '0;
      stable <= '0;
      pend <= '0;
      mask <= '0;
      irq <= 1'b0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1 <= button;
      sync <= s1;
      stable <= stable_nxt;
      pend <= pend_nxt;
      mask <= mask_nxt;
      irq <= |(pend_nxt & mask_nxt);
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_nxt[i];
    end
  end
endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed self-checking bench for button_ctrl with DEBOUNCE_CYCLES=4
module tb_button_ctrl;
  logic clk, rst, we, irq;
  logic [4:0] button;
  logic [1:0] addr;
  logic [31:0] wdata, rdata;
  int n_cmp = 0, n_err = 0;
  button_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .button(button), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1;
    addr = a;
    wdata = d;
    tick(1);
    we = 0;
    wdata = 0;
  endtask
  logic seen;
  initial begin
    rst = 1; button = 0; we = 0; addr = 0; wdata = 0;
    tick(1);
    rst = 0;
    chk_rd("reset_state", 0, 0);
    chk_rd("reset_pend", 1, 0);
    chk_rd("reset_mask", 2, 0);
    chk_rd("reset_rsvd", 3, 0);
    chk("reset_irq", {31'b0, irq}, 0);
    wr(3, 32'hffff_ffff);
    chk_rd("rsvd_write_ignored", 3, 0);
    wr(0, 32'h1f);
    chk_rd("state_write_ignored", 0, 0);
    button = 5'b00100;
    tick(5);
    chk_rd("press_state_edge5", 0, 0);
    chk_rd("press_pend_edge5", 1, 0);
    tick(1);
    chk_rd("press_state_edge6", 0, 32'h004);
    chk_rd("press_pend_edge6", 1, 32'h004);
    chk("press_irq_unmasked", {31'b0, irq}, 0);
    tick(4);
    wr(2, 32'hffff_e004);
    chk("mask_irq", {31'b0, irq}, 1);
    chk_rd("mask_read", 2, 32'h004);
    button = 5'b00101;
    tick(3);
    button = 5'b00100;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      addr = 0;
      #1;
      seen |= rdata[0];
    end
    chk("glitch_state_seen", {31'b0, seen}, 0);
    chk_rd("glitch_state", 0, 32'h004);
    chk_rd("glitch_pend", 1, 32'h004);
    button = 5'b00000;
    tick(5);
    chk_rd("release_pend_edge5", 1, 32'h004);
    tick(1);
    chk_rd("release_pend_edge6", 1, 32'h404);
    chk_rd("release_state", 0, 0);
    wr(1, 32'h400);
    chk_rd("w1c_release", 1, 32'h004);
    chk("w1c_irq_held", {31'b0, irq}, 1);
    wr(1, 32'h004);
    chk_rd("w1c_press", 1, 0);
    chk("w1c_irq_clear", {31'b0, irq}, 0);
    button = 5'b00001;
    tick(5);
    wr(1, 32'h001);
    chk_rd("collision_pend", 1, 32'h001);
    chk_rd("collision_state", 0, 32'h001);
    button = 5'b00010;
    tick(4);
    rst = 1;
    tick(1);
    chk_rd("midreset_state", 0, 0);
    chk_rd("midreset_pend", 1, 0);
    chk_rd("midreset_mask", 2, 0);
    rst = 0;
    tick(5);
    chk_rd("after_reset_edge5", 0, 0);
    tick(1);
    chk_rd("after_reset_state", 0, 32'h002);
    chk_rd("after_reset_pend", 1, 32'h002);
    chk("after_reset_irq", {31'b0, irq}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
